// File: rtl/ps2_kbd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_ctrl_pkg
// Purpose  : Shared constants and types for the PS/2 keyboard controller
// Revision : 1.0 - initial release
// ============================================================================
package ps2_kbd_ctrl_pkg;

  // Mirrors `KbWidth from defines.v
  localparam int KB_WIDTH_DEF       = 8;
  localparam int PS2_FRAME_BITS     = 11;
  localparam int TIMEOUT_CYCLES_DEF = 50000;

  // Address-independent keyboard status word: bit0 = ready, bit1 = overflow
  typedef struct packed {
    logic overflow;
    logic ready;
  } kbStatus_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frameState_t;

endpackage
`default_nettype wire

// File: rtl/ps2_kbd_ctrl_kb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : kb_fifo
// Purpose  : Synchronous FIFO with extra-MSB pointers and combinational head
// Revision : 1.0 - initial release
// ============================================================================
module kb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wrPtr;
  logic [c_AW:0]    r_rdPtr;
  logic             w_doPop;
  logic             w_doPush;

  assign empty    = (r_wrPtr == r_rdPtr);
  assign full     = (r_wrPtr[c_AW] != r_rdPtr[c_AW]) &&
                    (r_wrPtr[c_AW-1:0] == r_rdPtr[c_AW-1:0]);
  assign w_doPop  = pop && !empty;
  // A simultaneous pop frees the slot the write lands in
  assign w_doPush = push && (!full || w_doPop);
  assign rdata    = r_mem[r_rdPtr[c_AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr[c_AW-1:0]] <= wdata;
        r_wrPtr                  <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_ctrl
// Purpose  : PS/2 device-to-host receiver feeding a scan-code FIFO for MMIO
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_ctrl
  import ps2_kbd_ctrl_pkg::*;
#(
  parameter int KB_WIDTH       = KB_WIDTH_DEF,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  input  logic                kb_rd,
  output logic [KB_WIDTH-1:0] kb_data,
  output logic                kb_ready,
  output logic                kb_overflow,
  output logic                frame_err
);

  localparam int                c_TIMER_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_TIMER_W-1:0] c_TIMER_MAX = c_TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam int                c_CNT_W     = $clog2(PS2_FRAME_BITS);
  localparam logic [c_CNT_W-1:0] c_LAST_DATA = c_CNT_W'(KB_WIDTH);

  logic [1:0]           r_clkSync;
  logic                 r_clkHist;
  logic [1:0]           r_dataSync;
  frameState_t          r_state;
  frameState_t          w_stateNext;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cntNext;
  logic [KB_WIDTH-1:0]  r_shift;
  logic [KB_WIDTH-1:0]  w_shiftNext;
  logic                 r_parity;
  logic                 w_parityNext;
  logic [c_TIMER_W-1:0] r_timer;
  logic [c_TIMER_W-1:0] w_timerNext;
  logic                 r_frameErr;
  logic                 w_frameErrNext;
  logic                 r_overflow;
  logic                 w_fallEdge;
  logic                 w_dataBit;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_drop;
  logic                 w_empty;
  logic                 w_full;

  assign w_fallEdge = r_clkHist && !r_clkSync[1];
  assign w_dataBit  = r_dataSync[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clkSync  <= 2'b11;
      r_clkHist  <= 1'b1;
      r_dataSync <= 2'b11;
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_timer    <= '0;
      r_frameErr <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_clkSync  <= {r_clkSync[0], ps2_clk};
      r_clkHist  <= r_clkSync[1];
      r_dataSync <= {r_dataSync[0], ps2_data};
      r_state    <= w_stateNext;
      r_cnt      <= w_cntNext;
      r_shift    <= w_shiftNext;
      r_parity   <= w_parityNext;
      r_timer    <= w_timerNext;
      r_frameErr <= w_frameErrNext;
      if (w_pop) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_cntNext      = r_cnt;
    w_shiftNext    = r_shift;
    w_parityNext   = r_parity;
    w_timerNext    = r_timer;
    w_push         = 1'b0;
    w_frameErrNext = 1'b0;

    // Watchdog only runs while a frame is partially received
    if (r_state == ST_IDLE || w_fallEdge) begin
      w_timerNext = '0;
    end else if (r_timer == c_TIMER_MAX) begin
      w_timerNext    = '0;
      w_stateNext    = ST_IDLE;
      w_cntNext      = '0;
      w_frameErrNext = 1'b1;
    end else begin
      w_timerNext = r_timer + 1'b1;
    end

    if (w_fallEdge) begin
      unique case (r_state)
        ST_IDLE: begin
          if (!w_dataBit) begin
            w_stateNext = ST_DATA;
            w_cntNext   = c_CNT_W'(1);
          end
        end
        ST_DATA: begin
          w_shiftNext = {w_dataBit, r_shift[KB_WIDTH-1:1]};
          w_cntNext   = r_cnt + 1'b1;
          if (r_cnt == c_LAST_DATA) begin
            w_stateNext = ST_PARITY;
          end
        end
        ST_PARITY: begin
          w_parityNext = w_dataBit;
          w_cntNext    = r_cnt + 1'b1;
          w_stateNext  = ST_STOP;
        end
        ST_STOP: begin
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
          if ((^{r_shift, r_parity}) && w_dataBit) begin
            w_push = 1'b1;
          end else begin
            w_frameErrNext = 1'b1;
          end
        end
        default: begin
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
        end
      endcase
    end
  end

  assign w_pop  = kb_rd && !w_empty;
  assign w_drop = w_push && w_full && !w_pop;

  kb_fifo #(
    .WIDTH (KB_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_kbFifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (r_shift),
    .pop   (w_pop),
    .rdata (kb_data),
    .empty (w_empty),
    .full  (w_full)
  );

  assign kb_ready    = !w_empty;
  assign kb_overflow = r_overflow;
  assign frame_err   = r_frameErr;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kbd_ctrl
// Purpose  : Self-checking bench for ps2_kbd_ctrl against a frame-level model
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_ctrl;

  localparam int c_T     = 200;
  localparam int c_DEPTH = 8;
  localparam int c_HALF  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       kb_rd = 1'b0;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       kb_overflow;
  logic       frame_err;

  int         nChecks = 0;
  int         nFails = 0;
  int         errSeen = 0;
  int         mErr = 0;
  logic [7:0] mq[$];
  logic       mOvf = 1'b0;

  ps2_kbd_ctrl #(
    .KB_WIDTH       (8),
    .FIFO_DEPTH     (c_DEPTH),
    .TIMEOUT_CYCLES (c_T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .kb_rd       (kb_rd),
    .kb_data     (kb_data),
    .kb_ready    (kb_ready),
    .kb_overflow (kb_overflow),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && frame_err) errSeen++;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkHead(input string tag);
    checkVal({tag, "_ready"}, {31'd0, kb_ready}, {31'd0, mq.size() != 0});
    if (mq.size() != 0) checkVal({tag, "_data"}, {24'd0, kb_data}, {24'd0, mq[0]});
    checkVal({tag, "_ovf"}, {31'd0, kb_overflow}, {31'd0, mOvf});
  endtask

  task automatic sendBit(input logic b);
    @(posedge clk); #1 ps2_data = b;
    repeat (c_HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (c_HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  // Full frame; checks latency of push/error around the stop-bit edge
  task automatic sendFrame(input logic [7:0] b, input bit badPar, input bit stopVal,
                           input bit popAtStop);
    logic par;
    bit   good;
    par  = (~^b) ^ badPar;
    good = !badPar && stopVal;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(par);
    @(posedge clk); #1 ps2_data = stopVal;
    repeat (c_HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    @(posedge clk); @(negedge clk);
    checkVal("err_early1", {31'd0, frame_err}, 32'd0);
    checkHead("early1");
    @(posedge clk); #1 kb_rd = popAtStop;
    @(negedge clk);
    checkVal("err_early2", {31'd0, frame_err}, 32'd0);
    checkHead("early2");
    @(posedge clk);
    #1 kb_rd = 1'b0;
    if (popAtStop && mq.size() != 0) begin
      void'(mq.pop_front());
      mOvf = 1'b0;
    end
    if (good) begin
      if (mq.size() < c_DEPTH) mq.push_back(b);
      else mOvf = 1'b1;
    end else begin
      mErr++;
    end
    @(negedge clk);
    checkVal("frame_err", {31'd0, frame_err}, {31'd0, !good});
    checkHead("frame");
    @(posedge clk); @(negedge clk);
    checkVal("err_pulse", {31'd0, frame_err}, 32'd0);
    @(posedge clk); #1 ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic popBurst(input int n);
    @(negedge clk); kb_rd = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (mq.size() != 0) begin
        void'(mq.pop_front());
        mOvf = 1'b0;
      end
      @(negedge clk);
      if (i == n - 1) kb_rd = 1'b0;
      checkHead("pop");
    end
    kb_rd = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rst_ready", {31'd0, kb_ready}, 32'd0);
    checkVal("rst_ovf", {31'd0, kb_overflow}, 32'd0);
    checkVal("rst_err", {31'd0, frame_err}, 32'd0);
    checkVal("rst_data", {24'd0, kb_data}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Single good frame, then bad parity followed by a good frame
    sendFrame(8'h1C, 1'b0, 1'b1, 1'b0);
    popBurst(1);
    sendFrame(8'hF0, 1'b1, 1'b1, 1'b0);
    sendFrame(8'h1C, 1'b0, 1'b1, 1'b0);
    popBurst(1);

    // Overflow: nine frames into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) sendFrame(8'(i), 1'b0, 1'b1, 1'b0);
    checkVal("ovf_set", {31'd0, kb_overflow}, 32'd1);
    for (int i = 0; i < 8; i++) popBurst(1);

    // Full FIFO with a pop coinciding with the push
    for (int i = 1; i <= 8; i++) sendFrame(8'(i), 1'b0, 1'b1, 1'b0);
    sendFrame(8'h0A, 1'b0, 1'b1, 1'b1);
    checkVal("full_pop_ovf", {31'd0, kb_overflow}, 32'd0);
    popBurst(9);

    // Timeout after start plus four data bits
    sendBit(1'b0);
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
    @(posedge clk); #1 ps2_data = 1'b0;
    repeat (c_HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    n = 0;
    while (n < c_T + 20) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (frame_err) break;
    end
    mErr++;
    checkVal("timeout_lat", n, c_T + 3);
    @(posedge clk); @(negedge clk);
    checkVal("timeout_pulse", {31'd0, frame_err}, 32'd0);
    #1 ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    sendFrame(8'h55, 1'b0, 1'b1, 1'b0);
    popBurst(1);

    // Randomized frames, corruptions and pop bursts
    for (int k = 0; k < 30; k++) begin
      int r;
      r = $urandom_range(0, 99);
      sendFrame(8'($urandom), r < 15, !(r >= 15 && r < 25), $urandom_range(0, 3) == 0);
      popBurst($urandom_range(0, 3));
    end

    // Reset in the middle of frame 0xE1 (remaining bits are all ones)
    sendFrame(8'h77, 1'b0, 1'b1, 1'b0);
    sendBit(1'b0);
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b0); sendBit(1'b0); sendBit(1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    mq.delete();
    mOvf = 1'b0;
    @(negedge clk);
    checkVal("midrst_ready", {31'd0, kb_ready}, 32'd0);
    checkVal("midrst_ovf", {31'd0, kb_overflow}, 32'd0);
    checkVal("midrst_err", {31'd0, frame_err}, 32'd0);
    checkVal("midrst_data", {24'd0, kb_data}, 32'd0);
    n = errSeen;
    for (int i = 0; i < 5; i++) sendBit(1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkVal("midrst_noerr", errSeen - n, 0);
    checkVal("midrst_nopush", {31'd0, kb_ready}, 32'd0);
    sendFrame(8'h3A, 1'b0, 1'b1, 1'b0);
    popBurst(1);

    checkVal("err_total", errSeen, mErr);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
